pipe_skid_reg: RTL and testbench

- Parametrised successor to the fixed 32-bit IF/ID stage register, usable between any two pipeline stages.
- Replaces the single stall-enable with a valid/ready handshake.
- A two-entry skid buffer keeps in_ready registered, so upstream timing never depends combinationally on out_ready.
- Adds a synchronous flush that loads a configurable bubble value, an occupancy output and a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_skid_reg.sv | 142 ++++++++++++++
 tb/tb_pipe_skid_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: parametrised pipeline stage register with a valid/ready
// handshake and a two-entry skid buffer. in_ready comes straight from a
// flop, so the upstream stage never sees a combinational path from out_ready.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous flush, drops held and incoming beats
//   in_valid   upstream beat valid
//   in_ready   block can accept a beat (registered)
//   in_data    upstream payload, sampled only when in_valid & in_ready
//   out_valid  out_data holds a valid beat
//   out_ready  downstream accepts
//   out_data   payload, driven directly from the main register
//   occupancy  beats held, 0..2
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
//   stall_clr  synchronous clear of stall_cnt
//
// state | meaning
// EMPTY | main and skid invalid, both hold BUBBLE_VAL
// ONE   | main valid, skid holds BUBBLE_VAL
// FULL  | main and skid valid, skid holds the younger beat

module pipe_skid_reg #(
    parameter int unsigned          DATA_W     = 32,
    parameter logic [DATA_W-1:0]    BUBBLE_VAL = '0,
    parameter int unsigned          CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic                in_ready_q, in_ready_d;
    logic [CNT_W-1:0]    stall_q, stall_d;

    logic in_fire;
    logic out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end

        // Registering the next-state decode keeps in_ready free of any
        // same-cycle dependence on out_ready.
        in_ready_d = (state_d != FULL);

        stall_d = stall_q;
        if (stall_clr) begin
            stall_d = '0;
        end else if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_q     <= BUBBLE_VAL;
            skid_q     <= BUBBLE_VAL;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    localparam int unsigned DW  = 64;
    localparam int unsigned CW  = 4;
    localparam logic [DW-1:0] BUB = 64'h13;
    localparam int unsigned SMAX = 15;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;
    logic          stall_clr;

    int n_vec;
    int n_err;

    // Reference model: the stage is a FIFO of at most two beats.
    logic [DW-1:0] q[$];
    int unsigned   m_stall;

    pipe_skid_reg #(
        .DATA_W    (DW),
        .BUBBLE_VAL(BUB),
        .CNT_W     (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt),
        .stall_clr(stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("out_data",  out_data, (q.size() != 0) ? q[0] : BUB);
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("in_ready",  64'(in_ready), 64'(q.size() != 2));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    endtask

    task automatic model_update();
        bit ifire;
        bit ofire;
        ifire = in_valid && (q.size() < 2);
        ofire = (q.size() > 0) && out_ready;
        if (stall_clr)
            m_stall = 0;
        else if ((q.size() > 0) && !out_ready && (m_stall < SMAX))
            m_stall++;
        if (flush) begin
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back(in_data);
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        stall_clr = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        m_stall = 0;
        q.delete();
        rst = 1'b0;
        idle_inputs();
        #12;
        check_all();
        rst = 1'b1;

        // streaming at full throughput
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1;
            in_data  = 64'(k);
            step();
            chk("t1_data", out_data, 64'(k));
            chk("t1_occ", 64'(occupancy), 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("t1_stall", 64'(stall_cnt), 64'd0);

        // backpressure fills the skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        step();
        in_data = 64'hB;
        step();
        chk("t2_occ_full", 64'(occupancy), 64'd2);
        chk("t2_ready_lo", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("t2_stall", 64'(stall_cnt), 64'd4);
        chk("t2_head", out_data, 64'hA);
        out_ready = 1'b1;
        step();
        chk("t2_second", out_data, 64'hB);
        step();
        chk("t2_drained", out_data, BUB);
        chk("t2_occ0", 64'(occupancy), 64'd0);

        // flush while full, coinciding with a new beat
        stall_clr = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h21;
        step();
        stall_clr = 1'b0;
        in_data   = 64'h22;
        step();
        flush   = 1'b1;
        in_data = 64'hC;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t3_valid", 64'(out_valid), 64'd0);
        chk("t3_ready", 64'(in_ready), 64'd1);
        chk("t3_data", out_data, BUB);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_no_C", 64'(out_valid), 64'd0);
        end

        // asynchronous reset while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h31;
        step();
        in_data = 64'h32;
        step();
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        q.delete();
        m_stall = 0;
        check_all();
        chk("t4_data_rst", out_data, BUB);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h5;
        step();
        chk("t4_beat5", out_data, 64'h5);
        in_valid = 1'b0;
        step();

        // stall counter saturation and clear
        stall_clr = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h77;
        step();
        stall_clr = 1'b0;
        in_valid  = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk("t5_sat", 64'(stall_cnt), 64'd15);
        stall_clr = 1'b1;
        step();
        chk("t5_clr", 64'(stall_cnt), 64'd0);
        stall_clr = 1'b0;
        step();
        chk("t5_restart", 64'(stall_cnt), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;

        // random traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            if ((c % 100) < 20)
                out_ready = 1'b0;
            else
                out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            stall_clr = ($urandom_range(0, 15) == 0);
            step();
        end

        // long stall then release must drain without deadlock
        flush     = 1'b0;
        stall_clr = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = {$urandom, $urandom};
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() != 0; k++) step();
        chk("drain_done", 64'(occupancy), 64'd0);
        chk("drain_bubble", out_data, BUB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
